// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - glyphs, FSM encoding and shared types for the BCD display scanner
package bcd_display_pkg;

   // Segment order {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] GLYPH_0     = 7'b1000000;
   localparam logic [6:0] GLYPH_1     = 7'b1111001;
   localparam logic [6:0] GLYPH_2     = 7'b0100100;
   localparam logic [6:0] GLYPH_3     = 7'b0110000;
   localparam logic [6:0] GLYPH_4     = 7'b0011001;
   localparam logic [6:0] GLYPH_5     = 7'b0010010;
   localparam logic [6:0] GLYPH_6     = 7'b0000010;
   localparam logic [6:0] GLYPH_7     = 7'b1111000;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;
   localparam logic [6:0] GLYPH_9     = 7'b0010000;
   localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
   localparam logic [6:0] GLYPH_O     = 7'b0100011;
   localparam logic [6:0] GLYPH_C     = 7'b1000110;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   // One captured ALU result with its flags.
   typedef struct packed {
      logic [11:0] bcd;
      logic        carry;
      logic        ovf;
   } sample_t;

   // True when any of the three nibbles is not a decimal digit.
   function automatic logic has_invalid(input logic [11:0] v);
      return (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
   endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// rtl/bcd_display_scanner_if.sv - value/flag input and display output bundle
interface bcd_display_scanner_if;
   logic [11:0] bcd;
   logic        CarryOUT;
   logic        overflow;
   logic        load;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic        err;
   logic        frame_tick;

   modport master (
      output bcd, CarryOUT, overflow, load,
      input  seg, an, dp, err, frame_tick
   );

   modport slave (
      input  bcd, CarryOUT, overflow, load,
      output seg, an, dp, err, frame_tick
   );
endinterface

// File: rtl/bcd_display_scanner_seg7_decoder.sv
// rtl/bcd_display_scanner_seg7_decoder.sv - nibble to active-low seven-segment glyph
module seg7_decoder
   import bcd_display_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   // Decimal digits get their glyph, anything above 9 shows a dash.
   always_comb begin
      seg_o = GLYPH_DASH;
      case (nibble_i)
         4'd0: seg_o = GLYPH_0;
         4'd1: seg_o = GLYPH_1;
         4'd2: seg_o = GLYPH_2;
         4'd3: seg_o = GLYPH_3;
         4'd4: seg_o = GLYPH_4;
         4'd5: seg_o = GLYPH_5;
         4'd6: seg_o = GLYPH_6;
         4'd7: seg_o = GLYPH_7;
         4'd8: seg_o = GLYPH_8;
         4'd9: seg_o = GLYPH_9;
         default: seg_o = GLYPH_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - tear-free multiplexed 4-digit display of a BCD ALU result
module bcd_display_scanner
   import bcd_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter bit BLANK_LZ    = 1'b1
)
(
   input logic clk,
   input logic rst_n,
   bcd_display_scanner_if.slave bus
);

   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   sample_t       hold_q, hold_d, disp_q, disp_d;
   logic          pend_q, pend_d;
   state_e        state_q, state_d;

   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;
   logic          dp_q, dp_d, err_q, err_d, ft_q, ft_d;

   logic          slot_tick, frame_wrap, transfer;
   logic [3:0]    nibble;
   logic [6:0]    dec_seg;

   assign slot_tick  = (presc_q == PRESC_LAST);
   assign frame_wrap = slot_tick && (idx_q == 2'd3);
   // A load on the wrap cycle wins over the transfer, so that value waits one more frame.
   assign transfer   = frame_wrap && pend_q && !bus.load;

   // Scan counters, holding register capture and frame-synchronous transfer.
   always_comb begin
      presc_d = slot_tick ? '0 : presc_q + 1'b1;
      idx_d   = slot_tick ? idx_q + 2'd1 : idx_q;
      hold_d  = hold_q;
      pend_d  = pend_q;
      disp_d  = disp_q;
      if (bus.load) begin
         hold_d.bcd   = bus.bcd;
         hold_d.carry = bus.CarryOUT;
         hold_d.ovf   = bus.overflow;
         pend_d       = 1'b1;
      end else if (transfer) begin
         disp_d = hold_q;
         pend_d = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         idx_q   <= 2'd0;
         hold_q  <= '0;
         disp_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         disp_q  <= disp_d;
         pend_q  <= pend_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_BLANK;
      else        state_q <= state_d;
   end

   // FSM next state: the first transfer starts the display, only reset stops it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BLANK: if (transfer) state_d = ST_RUN;
         ST_RUN:   state_d = ST_RUN;
         default:  state_d = ST_BLANK;
      endcase
   end

   // Pick the nibble for the digit being driven next cycle.
   always_comb begin
      nibble = disp_d.bcd[3:0];
      case (idx_d)
         2'd1:    nibble = disp_d.bcd[7:4];
         2'd2:    nibble = disp_d.bcd[11:8];
         default: nibble = disp_d.bcd[3:0];
      endcase
   end

   seg7_decoder u_dec (
      .nibble_i (nibble),
      .seg_o    (dec_seg)
   );

   // FSM outputs, computed from next-state values so the registered pins line up with the scan.
   always_comb begin
      logic h_zero, t_zero;
      logic [6:0] digit_seg;
      h_zero    = (disp_d.bcd[11:8] == 4'd0);
      t_zero    = (disp_d.bcd[7:4] == 4'd0);
      digit_seg = dec_seg;
      case (idx_d)
         2'd1: if (BLANK_LZ && h_zero && t_zero) digit_seg = GLYPH_BLANK;
         2'd2: if (BLANK_LZ && h_zero)           digit_seg = GLYPH_BLANK;
         2'd3: digit_seg = disp_d.ovf ? GLYPH_O : (disp_d.carry ? GLYPH_C : GLYPH_BLANK);
         default: digit_seg = dec_seg;
      endcase
      seg_d = GLYPH_BLANK;
      an_d  = 4'hF;
      dp_d  = 1'b1;
      if (state_d == ST_RUN) begin
         seg_d = digit_seg;
         an_d  = (presc_d == '0) ? 4'hF : ~(4'b0001 << idx_d);
         dp_d  = !((idx_d == 2'd3) && disp_d.ovf && disp_d.carry);
      end
      err_d = has_invalid(disp_d.bcd);
      ft_d  = frame_wrap;
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= GLYPH_BLANK;
         an_q  <= 4'hF;
         dp_q  <= 1'b1;
         err_q <= 1'b0;
         ft_q  <= 1'b0;
      end else begin
         seg_q <= seg_d;
         an_q  <= an_d;
         dp_q  <= dp_d;
         err_q <= err_d;
         ft_q  <= ft_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.dp         = dp_q;
   assign bus.err        = err_q;
   assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic clk = 1'b0;
   logic rst_n;

   bcd_display_scanner_if bus();

   bcd_display_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   string phase = "reset";

   // Reference model: time since reset, what was last loaded, what is shown.
   int          ticks;
   logic [11:0] m_hold, m_disp;
   bit          m_hold_c, m_hold_o, m_disp_c, m_disp_o;
   bit          m_pend, m_run, m_ft;

   logic [6:0] digit_glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                    7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   function automatic logic [6:0] glyph(input logic [3:0] n);
      if (n > 4'd9) return 7'b0111111;
      return digit_glyph[int'(n)];
   endfunction

   task automatic model_reset();
      ticks = 0; m_hold = '0; m_disp = '0;
      m_hold_c = 0; m_hold_o = 0; m_disp_c = 0; m_disp_o = 0;
      m_pend = 0; m_run = 0; m_ft = 0;
   endtask

   task automatic cmp(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
      end
   endtask

   task automatic check();
      int p, i;
      logic [3:0] h, t, o;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_dp, e_err;
      p = ticks % DIV;
      i = (ticks / DIV) % 4;
      h = m_disp[11:8]; t = m_disp[7:4]; o = m_disp[3:0];
      e_err = (h > 9) || (t > 9) || (o > 9);
      if (!m_run) begin
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         e_an = (p == 0) ? 4'hF : ~(4'b0001 << i);
         case (i)
            0: e_seg = glyph(o);
            1: e_seg = (h == 0 && t == 0) ? 7'h7F : glyph(t);
            2: e_seg = (h == 0) ? 7'h7F : glyph(h);
            default: e_seg = m_disp_o ? 7'b0100011 : (m_disp_c ? 7'b1000110 : 7'h7F);
         endcase
         e_dp = !(i == 3 && m_disp_o && m_disp_c);
      end
      cmp("an",         12'(bus.an),         12'(e_an));
      cmp("seg",        12'(bus.seg),        12'(e_seg));
      cmp("dp",         12'(bus.dp),         12'(e_dp));
      cmp("err",        12'(bus.err),        12'(e_err));
      cmp("frame_tick", 12'(bus.frame_tick), 12'(m_ft));
   endtask

   // One clock: drive at the falling edge, update model at the rising edge, check at the next fall.
   task automatic step(input bit ld, input logic [11:0] b, input bit c, input bit o);
      bit wrap;
      bus.load = ld; bus.bcd = b; bus.CarryOUT = c; bus.overflow = o;
      @(posedge clk);
      wrap = (ticks % FRAME) == FRAME - 1;
      if (ld) begin
         m_hold = b; m_hold_c = c; m_hold_o = o; m_pend = 1;
      end else if (wrap && m_pend) begin
         m_disp = m_hold; m_disp_c = m_hold_c; m_disp_o = m_hold_o;
         m_pend = 0; m_run = 1;
      end
      m_ft = wrap;
      ticks++;
      @(negedge clk);
      bus.load = 1'b0;
      check();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, bus.bcd, bus.CarryOUT, bus.overflow);
   endtask

   task automatic align_to(input int slot_pos);
      for (int k = 0; k < FRAME && (ticks % FRAME) != slot_pos; k++) idle(1);
   endtask

   function automatic logic [11:0] rand_bcd();
      logic [11:0] v;
      for (int k = 0; k < 3; k++)
         v[k*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) v[11:8] = 4'd0;
      if ($urandom_range(0, 3) == 0) v[7:4]  = 4'd0;
      return v;
   endfunction

   initial begin
      rst_n = 1'b0;
      bus.load = 1'b0; bus.bcd = '0; bus.CarryOUT = 1'b0; bus.overflow = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check();
      rst_n = 1'b1;
      check();

      phase = "blank_idle";   idle(2 * FRAME + 3);
      phase = "load_127";     step(1, 12'h127, 0, 0); idle(2 * FRAME + 4);
      phase = "load_005";     step(1, 12'h005, 0, 0); idle(2 * FRAME + 1);
      phase = "load_0A3";     step(1, 12'h0A3, 0, 0); idle(2 * FRAME + 2);
      phase = "ovf_carry";    step(1, 12'h456, 1, 1); idle(2 * FRAME);
      phase = "carry_only";   step(1, 12'h908, 1, 0); idle(2 * FRAME + 3);

      phase = "two_loads";
      align_to(0);
      step(1, 12'h111, 0, 0); idle(3);
      step(1, 12'h222, 0, 0); idle(2 * FRAME);

      phase = "load_on_wrap";
      align_to(FRAME - 1);
      step(1, 12'h389, 0, 1); idle(3 * FRAME);

      phase = "random";
      for (int r = 0; r < 25; r++) begin
         step(1, rand_bcd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 2 * FRAME));
      end

      phase = "show_err";     step(1, 12'h0A3, 1, 1); idle(2 * FRAME);
      phase = "mid_reset";
      step(1, 12'h999, 1, 1);
      idle(DIV + 1);
      rst_n = 1'b0;
      #1;
      model_reset();
      check();
      @(negedge clk);
      check();
      rst_n = 1'b1;
      phase = "blank_after_reset"; idle(3 * FRAME + 2);
      phase = "reload";       step(1, 12'h042, 0, 0); idle(2 * FRAME + 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
